// File: rtl/mux_2to1_pkg.sv
// Shared constants for the 2:1 selector slice used across the MIPS32 datapath.
package mux_2to1_pkg;

  localparam int unsigned DefaultWidth  = 1;
  localparam int unsigned DatapathWidth = 32;

endpackage

// File: rtl/mux2_bit.sv
// One-bit 2:1 multiplexer built from gate primitives: result = select ? i1 : i0.
module mux2_bit (
  input  logic i0,
  input  logic i1,
  input  logic select,
  output logic result
);

  wire select_n;
  wire pick0;
  wire pick1;

  not u_not  (select_n, select);
  and u_and0 (pick0, i0, select_n);
  and u_and1 (pick1, i1, select);
  or  u_or   (result, pick0, pick1);

endmodule

// File: rtl/mux_2to1.sv
// WIDTH-bit 2:1 multiplexer with a zero-cycle combinational output and a
// registered copy for pipelined users.
module mux_2to1
  import mux_2to1_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  output logic [WIDTH-1:0] result,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             select,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] result_q
);

  // select fans out to every bit slice; no clock or reset on this path.
  for (genvar k = 0; k < WIDTH; k++) begin : g_bit
    mux2_bit u_bit (
      .i0     (i0[k]),
      .i1     (i1[k]),
      .select (select),
      .result (result[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
    end else begin
      result_q <= result;
    end
  end

endmodule

// File: tb/tb_mux_2to1.sv
// Self-checking bench for mux_2to1 at WIDTH=1 and WIDTH=32.
module tb_mux_2to1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        a_i0, a_i1, a_sel;
  logic        a_res, a_q;
  logic [31:0] b_i0, b_i1;
  logic        b_sel;
  logic [31:0] b_res, b_q;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux_2to1 #(.WIDTH(1)) dut1 (
    .result   (a_res),
    .i0       (a_i0),
    .i1       (a_i1),
    .select   (a_sel),
    .clk      (clk),
    .rst      (rst),
    .result_q (a_q)
  );

  mux_2to1 #(.WIDTH(32)) dut32 (
    .result   (b_res),
    .i0       (b_i0),
    .i1       (b_i1),
    .select   (b_sel),
    .clk      (clk),
    .rst      (rst),
    .result_q (b_q)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic i0;
    logic i1;
    logic sel;
    logic exp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [31:0] exp_res;
    logic [31:0] exp_q;

    a_i0 = 0; a_i1 = 0; a_sel = 0;
    b_i0 = '0; b_i1 = '0; b_sel = 0;

    // Truth table rows written as (i0, i1, select -> result).
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b1};

    for (int i = 0; i < 8; i++) begin
      a_i0 = tbl[i].i0; a_i1 = tbl[i].i1; a_sel = tbl[i].sel;
      #20;
      check($sformatf("truth_row%0d", i), {31'b0, a_res}, {31'b0, tbl[i].exp});
    end

    // Select toggle, purely combinational.
    a_i0 = 0; a_i1 = 1;
    a_sel = 0; #1; check("toggle_sel0", {31'b0, a_res}, 32'd0);
    a_sel = 1; #1; check("toggle_sel1", {31'b0, a_res}, 32'd1);
    a_sel = 0; #1; check("toggle_sel0b", {31'b0, a_res}, 32'd0);

    // Registered path: reset, then one-cycle latency.
    @(negedge clk);
    rst = 1; a_i0 = 0; a_i1 = 0; a_sel = 0;
    @(posedge clk); #1;
    check("q_after_reset", {31'b0, a_q}, 32'd0);
    check("q32_after_reset", b_q, 32'd0);
    @(negedge clk);
    rst = 0; a_i0 = 1; a_sel = 0;
    #1;
    check("q_not_before_edge", {31'b0, a_q}, 32'd0);
    check("res_with_clk_idle", {31'b0, a_res}, 32'd1);
    @(posedge clk); #1;
    check("q_one_cycle", {31'b0, a_q}, 32'd1);

    // Reset mid-operation clears the register but not the combinational output.
    @(negedge clk);
    rst = 1;
    #1;
    check("res_during_rst", {31'b0, a_res}, 32'd1);
    @(posedge clk); #1;
    check("q_mid_reset", {31'b0, a_q}, 32'd0);
    check("res_after_rst_edge", {31'b0, a_res}, 32'd1);
    @(negedge clk);
    rst = 0;

    // Wide directed patterns, including i0 == i1.
    b_i0 = 32'hDEADBEEF; b_i1 = 32'h12345678;
    b_sel = 0; #1; check("w32_sel0", b_res, 32'hDEADBEEF);
    b_sel = 1; #1; check("w32_sel1", b_res, 32'h12345678);
    b_i1 = 32'hDEADBEEF;
    b_sel = 0; #1; check("w32_eq_sel0", b_res, 32'hDEADBEEF);
    b_sel = 1; #1; check("w32_eq_sel1", b_res, 32'hDEADBEEF);

    // Randomized traffic against a simple reference: pick-by-select, then delay one edge.
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      b_i0  = $urandom;
      b_i1  = $urandom;
      b_sel = 1'($urandom_range(0, 1));
      rst   = ($urandom_range(0, 9) == 0);
      exp_res = b_sel ? b_i1 : b_i0;
      #1;
      check("rand_res", b_res, exp_res);
      exp_q = rst ? 32'd0 : exp_res;
      @(posedge clk); #1;
      check("rand_q", b_q, exp_q);
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
